// File: rtl/layer_serializer_if.sv
// Producer-vector / serial-stream bundle for layer_serializer.
// The slave side is the serializer; the master side is whoever drives the vector.
interface layer_serializer_if #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
);
  logic [NN-1:0]           i_valid;
  logic [NN*dataWidth-1:0] i_data;
  logic                    x_valid;
  logic [dataWidth-1:0]    x_out;
  logic                    o_last;
  logic                    o_busy;
  logic                    o_overflow;
  logic                    o_skew;

  modport slave (
    input  i_valid, i_data,
    output x_valid, x_out, o_last, o_busy, o_overflow, o_skew
  );

  modport master (
    output i_valid, i_data,
    input  x_valid, x_out, o_last, o_busy, o_overflow, o_skew
  );
endinterface

// File: rtl/layer_serializer.sv
// Converts a parallel layer-output vector into a serial word burst for the next layer,
// with an active buffer plus a one-deep pending buffer for zero-gap back-to-back bursts.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  layer_serializer_if.slave bus
);

  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;
  typedef logic [NN-1:0][dataWidth-1:0] vec_t;

  state_t               r_state,     w_state_nxt;
  vec_t                 r_active,    w_active_nxt;
  vec_t                 r_pending,   w_pending_nxt;
  logic                 r_pend_full, w_pend_full_nxt;
  logic [IW-1:0]        r_idx,       w_idx_nxt;
  logic [dataWidth-1:0] r_x_out,     w_x_out_nxt;
  logic                 r_last,      w_last_nxt;
  logic                 r_overflow,  w_overflow_nxt;
  logic                 r_skew;

  logic w_capture;
  logic w_partial;

  assign w_capture = &bus.i_valid;
  assign w_partial = (|bus.i_valid) & ~w_capture;

  // r_idx always names the word currently on x_out, so the next-word decision is made
  // on the edge that ends the word being shown.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_pend_full_nxt = r_pend_full;
    w_idx_nxt       = r_idx;
    w_overflow_nxt  = r_overflow;

    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_active_nxt = bus.i_data;
          w_idx_nxt    = '0;
          w_state_nxt  = SEND;
        end
      end
      SEND: begin
        if (r_idx != LAST) begin
          w_idx_nxt = r_idx + 1'b1;
          if (w_capture) begin
            if (r_pend_full) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_pending_nxt   = bus.i_data;
              w_pend_full_nxt = 1'b1;
            end
          end
        end else if (r_pend_full) begin
          // Pending slot frees up on this edge, so a simultaneous capture refills it.
          w_active_nxt    = r_pending;
          w_idx_nxt       = '0;
          w_pending_nxt   = w_capture ? bus.i_data : r_pending;
          w_pend_full_nxt = w_capture;
        end else if (w_capture) begin
          w_active_nxt = bus.i_data;
          w_idx_nxt    = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_x_out_nxt = (w_state_nxt == SEND) ? w_active_nxt[w_idx_nxt] : r_x_out;
    w_last_nxt  = (w_state_nxt == SEND) && (w_idx_nxt == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_idx       <= '0;
      r_x_out     <= '0;
      r_last      <= 1'b0;
      r_overflow  <= 1'b0;
      r_skew      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_pend_full <= w_pend_full_nxt;
      r_idx       <= w_idx_nxt;
      r_x_out     <= w_x_out_nxt;
      r_last      <= w_last_nxt;
      r_overflow  <= w_overflow_nxt;
      r_skew      <= r_skew | w_partial;
    end
  end

  assign bus.x_valid    = (r_state == SEND);
  assign bus.o_busy     = (r_state == SEND);
  assign bus.x_out      = r_x_out;
  assign bus.o_last     = r_last;
  assign bus.o_overflow = r_overflow;
  assign bus.o_skew     = r_skew;

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer (NN=4, dataWidth=16): stimulus queues expected
// words and burst lengths, a negedge monitor pops and compares them.
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer_serializer_if #(.NN(NN), .dataWidth(DW)) bus ();

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   run_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   run_len = 0;

  localparam logic [63:0] VA = 64'h0004_0003_0002_0001;
  localparam logic [63:0] VB = 64'hBBB3_BBB2_BBB1_BBB0;
  localparam logic [63:0] VC = 64'hCCC3_CCC2_CCC1_CCC0;
  localparam logic [63:0] VN = 64'h5553_5552_5551_5550;
  localparam logic [63:0] VD = 64'hD0D3_D0D2_D0D1_D0D0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Inputs change 1ns after the rising edge and are sampled on the next one.
  task automatic step(input logic [NN-1:0] v, input logic [63:0] d);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    #1;
    bus.i_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0);
  endtask

  task automatic push_words(input logic [63:0] d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = d[i*DW +: DW];
      e.last = (i == NN - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.x_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", bus.x_out, '0);
      end else begin
        e = exp_q.pop_front();
        check("x_out", bus.x_out, e.data);
        check("o_last", bus.o_last, e.last);
      end
      run_len++;
    end else if (run_len != 0) begin
      if (run_q.size() == 0) check("unexpected_run", run_len, 0);
      else check("burst_len", run_len, run_q.pop_front());
      run_len = 0;
    end
  end

  initial begin
    int busy_cnt;
    bus.i_valid = '0;
    bus.i_data  = '0;

    #2 rst = 1'b0;
    #1;
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_x_out", bus.x_out, 0);
    check("rst_o_busy", bus.o_busy, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_flags", {bus.o_overflow, bus.o_skew}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single vector: four words, busy for exactly four cycles.
    push_words(VA, 4);
    run_q.push_back(4);
    step('1, VA);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_busy) busy_cnt++;
      step('0, '0);
    end
    check("busy_cycles", busy_cnt, 4);
    check("flags_after_single", {bus.o_overflow, bus.o_skew}, 0);
    idle(3);

    // B arrives while word 1 of A is shown: 8 contiguous words.
    push_words(VA, 4);
    push_words(VB, 4);
    run_q.push_back(8);
    step('1, VA);
    step('0, '0);
    step('1, VB);
    idle(10);
    check("ovf_after_ab", bus.o_overflow, 0);

    // Capture on A's last word with pending empty: 8 contiguous words.
    push_words(VA, 4);
    push_words(VN, 4);
    run_q.push_back(8);
    step('1, VA);
    idle(3);
    step('1, VN);
    idle(10);

    // Same with B already pending: A, B, N back to back, 12 words, no overflow.
    push_words(VA, 4);
    push_words(VB, 4);
    push_words(VN, 4);
    run_q.push_back(12);
    step('1, VA);
    step('1, VB);
    idle(2);
    step('1, VN);
    idle(14);
    check("ovf_after_abn", bus.o_overflow, 0);

    // Partial valid while idle: ignored, skew flag set.
    check("skew_before", bus.o_skew, 0);
    step(4'b0111, VC);
    check("skew_set", bus.o_skew, 1);
    check("busy_after_skew", bus.o_busy, 0);
    idle(3);
    check("skew_sticky", bus.o_skew, 1);

    // A, then B at word 1, C at word 2: C dropped, overflow sticky.
    push_words(VA, 4);
    push_words(VB, 4);
    run_q.push_back(8);
    step('1, VA);
    step('0, '0);
    step('1, VB);
    check("ovf_before_c", bus.o_overflow, 0);
    step('1, VC);
    check("ovf_after_c", bus.o_overflow, 1);
    idle(12);
    check("ovf_sticky", bus.o_overflow, 1);

    // Reset while word 2 shows with B pending: burst aborted, flags cleared.
    push_words(VA, 3);
    run_q.push_back(3);
    step('1, VA);
    step('1, VB);
    step('0, '0);
    #5;
    rst = 1'b0;
    #1;
    check("midrst_x_valid", bus.x_valid, 0);
    check("midrst_x_out", bus.x_out, 0);
    check("midrst_o_last", bus.o_last, 0);
    check("midrst_o_busy", bus.o_busy, 0);
    check("midrst_flags", {bus.o_overflow, bus.o_skew}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_quiet", bus.x_valid, 0);
      step('0, '0);
    end

    push_words(VD, 4);
    run_q.push_back(4);
    step('1, VD);
    idle(8);

    check("exp_words_drained", exp_q.size(), 0);
    check("exp_runs_drained", run_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
